// File: rtl/rv_plic_target_multi.sv
// Multi-target PLIC arbiter with shared claim/complete in-flight tracking.
// Optional: define RV_PLIC_COMPLETE_CHECK_EN to add err_o (invalid-complete pulse).
module rv_plic_target_multi #(
  parameter int N_SOURCE = 32,
  parameter int N_TARGET = 2,
  parameter int MAX_PRIO = 7,
  parameter int SRCW     = $clog2(N_SOURCE + 1),
  parameter int PRIOW    = $clog2(MAX_PRIO + 1),
  parameter int TGTW     = (N_TARGET > 1) ? $clog2(N_TARGET) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_SOURCE-1:0]          ip,
  input  logic [N_TARGET*N_SOURCE-1:0] ie,
  input  logic [N_SOURCE*PRIOW-1:0]    prio,
  input  logic [N_TARGET*PRIOW-1:0]    threshold,
  input  logic [N_TARGET-1:0]          claim_valid_i,
  input  logic [N_TARGET-1:0]          complete_valid_i,
  input  logic [N_TARGET*SRCW-1:0]     complete_id_i,
  output logic [N_TARGET-1:0]          irq_o,
  output logic [N_TARGET*SRCW-1:0]     irq_id_o,
  output logic [N_TARGET*SRCW-1:0]     claim_id_o,
  output logic [N_TARGET-1:0]          claim_ack_o,
  output logic [N_SOURCE-1:0]          inflight_o
`ifdef RV_PLIC_COMPLETE_CHECK_EN
  ,
  output logic [N_TARGET-1:0]          err_o
`endif
);

  logic [N_SOURCE-1:0]                inflight_q, inflight_d;
  logic [N_SOURCE-1:0][TGTW-1:0]      owner_q, owner_d;
  logic [N_TARGET-1:0][SRCW-1:0]      irq_id_q, irq_id_d;
  logic [N_TARGET-1:0][SRCW-1:0]      claim_id_q, claim_id_d;
  logic [N_TARGET-1:0]                irq_q, irq_d;
  logic [N_TARGET-1:0]                claim_ack_q, claim_ack_d;
  logic [N_SOURCE-1:0]                claim_set;
  logic [N_SOURCE-1:0]                complete_clr;
  logic [PRIOW-1:0]                   best_prio;
  logic [SRCW-1:0]                    best_id;

  always_comb begin
    claim_set    = '0;
    complete_clr = '0;
    owner_d      = owner_q;
    claim_id_d   = claim_id_q;
    claim_ack_d  = claim_valid_i;
    irq_id_d     = '0;
    irq_d        = '0;
    best_prio    = '0;
    best_id      = '0;

    // Ascending target order gives the lowest index priority on a shared claim.
    for (int t = 0; t < N_TARGET; t++) begin
      if (claim_valid_i[t]) begin
        claim_id_d[t] = '0;
        for (int s = 0; s < N_SOURCE; s++) begin
          if (irq_id_q[t] == SRCW'(s + 1) && !claim_set[s] && !inflight_q[s]) begin
            claim_set[s]  = 1'b1;
            owner_d[s]    = TGTW'(t);
            claim_id_d[t] = irq_id_q[t];
          end
        end
      end
    end

    for (int t = 0; t < N_TARGET; t++) begin
      if (complete_valid_i[t]) begin
        for (int s = 0; s < N_SOURCE; s++) begin
          if (complete_id_i[t*SRCW +: SRCW] == SRCW'(s + 1) &&
              inflight_q[s] && owner_q[s] == TGTW'(t)) begin
            complete_clr[s] = 1'b1;
          end
        end
      end
    end

    inflight_d = (inflight_q | claim_set) & ~complete_clr;

    // Seeding best_prio with the threshold makes "prio > threshold" and
    // "prio 0 never wins" fall out of the strict comparison; ties keep the lower index.
    for (int t = 0; t < N_TARGET; t++) begin
      best_prio = threshold[t*PRIOW +: PRIOW];
      best_id   = '0;
      for (int s = 0; s < N_SOURCE; s++) begin
        if (ip[s] && ie[t*N_SOURCE + s] && !inflight_d[s] &&
            prio[s*PRIOW +: PRIOW] > best_prio) begin
          best_prio = prio[s*PRIOW +: PRIOW];
          best_id   = SRCW'(s + 1);
        end
      end
      irq_id_d[t] = best_id;
      irq_d[t]    = (best_id != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q  <= '0;
      owner_q     <= '0;
      irq_id_q    <= '0;
      irq_q       <= '0;
      claim_id_q  <= '0;
      claim_ack_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      owner_q     <= owner_d;
      irq_id_q    <= irq_id_d;
      irq_q       <= irq_d;
      claim_id_q  <= claim_id_d;
      claim_ack_q <= claim_ack_d;
    end
  end

  assign irq_o       = irq_q;
  assign irq_id_o    = irq_id_q;
  assign claim_id_o  = claim_id_q;
  assign claim_ack_o = claim_ack_q;
  assign inflight_o  = inflight_q;

`ifdef RV_PLIC_COMPLETE_CHECK_EN
  logic [N_TARGET-1:0] err_q, err_d;

  always_comb begin
    err_d = '0;
    for (int t = 0; t < N_TARGET; t++) begin
      err_d[t] = complete_valid_i[t];
      for (int s = 0; s < N_SOURCE; s++) begin
        if (complete_id_i[t*SRCW +: SRCW] == SRCW'(s + 1) &&
            inflight_q[s] && owner_q[s] == TGTW'(t)) begin
          err_d[t] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_rv_plic_target_multi.sv
// Directed bench for rv_plic_target_multi (N_SOURCE=32, N_TARGET=2, MAX_PRIO=7).
module tb_rv_plic_target_multi;
  localparam int NS = 32;
  localparam int NT = 2;
  localparam int SW = 6;
  localparam int PW = 3;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [NS-1:0]    ip;
  logic [NT*NS-1:0] ie;
  logic [NS*PW-1:0] prio;
  logic [NT*PW-1:0] threshold;
  logic [NT-1:0]    claim_valid_i;
  logic [NT-1:0]    complete_valid_i;
  logic [NT*SW-1:0] complete_id_i;
  logic [NT-1:0]    irq_o;
  logic [NT*SW-1:0] irq_id_o;
  logic [NT*SW-1:0] claim_id_o;
  logic [NT-1:0]    claim_ack_o;
  logic [NS-1:0]    inflight_o;
`ifdef RV_PLIC_COMPLETE_CHECK_EN
  logic [NT-1:0]    err_o;
`endif

  int checks = 0;
  int failures = 0;

  rv_plic_target_multi #(.N_SOURCE(NS), .N_TARGET(NT), .MAX_PRIO(7)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ip               (ip),
    .ie               (ie),
    .prio             (prio),
    .threshold        (threshold),
    .claim_valid_i    (claim_valid_i),
    .complete_valid_i (complete_valid_i),
    .complete_id_i    (complete_id_i),
    .irq_o            (irq_o),
    .irq_id_o         (irq_id_o),
    .claim_id_o       (claim_id_o),
    .claim_ack_o      (claim_ack_o),
    .inflight_o       (inflight_o)
`ifdef RV_PLIC_COMPLETE_CHECK_EN
    ,
    .err_o            (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_prio(input int s, input int p);
    prio[s*PW +: PW] = PW'(p);
  endtask

  task automatic check_err(input string tag, input logic [NT-1:0] exp);
`ifdef RV_PLIC_COMPLETE_CHECK_EN
    check(tag, 64'(err_o), 64'(exp));
`else
    check(tag, 64'(inflight_o & 32'h0), 64'(exp & 2'b00));
`endif
  endtask

  initial begin
    // Reset with everything asserted: strobes and pending must be ignored.
    rst_i            = 1'b1;
    ip               = '1;
    ie               = '1;
    prio             = '1;
    threshold        = '0;
    claim_valid_i    = '1;
    complete_valid_i = '1;
    complete_id_i    = {6'd1, 6'd1};
    tick();
    tick();
    check("rst_irq",      64'(irq_o),       64'h0);
    check("rst_irq_id",   64'(irq_id_o),    64'h0);
    check("rst_claim_id", 64'(claim_id_o),  64'h0);
    check("rst_ack",      64'(claim_ack_o), 64'h0);
    check("rst_inflight", 64'(inflight_o),  64'h0);
    check_err("rst_err", 2'b00);

    // Idle after release with no enables.
    rst_i            = 1'b0;
    claim_valid_i    = '0;
    complete_valid_i = '0;
    complete_id_i    = '0;
    ie               = '0;
    tick();
    tick();
    check("idle_irq", 64'(irq_o), 64'h0);

    // Priority tie between sources 3 and 9 (IDs 4, 10): lower index wins.
    ip   = '0; ip[3] = 1'b1; ip[9] = 1'b1;
    prio = '0; set_prio(3, 5); set_prio(9, 5);
    ie   = '0; ie[3] = 1'b1; ie[9] = 1'b1;
    threshold = {3'd0, 3'd2};
    tick();
    check("tie_id0", 64'(irq_id_o[5:0]), 64'd4);
    check("tie_irq", 64'(irq_o),         64'b01);
    set_prio(9, 6);
    tick();
    check("hi_id0", 64'(irq_id_o[5:0]), 64'd10);

    // Threshold equal to priority masks; prio 0 never wins.
    set_prio(9, 0); set_prio(3, 3);
    threshold = {3'd0, 3'd3};
    tick();
    check("thr_eq_irq", 64'(irq_o),         64'b00);
    check("thr_eq_id",  64'(irq_id_o[5:0]), 64'd0);
    threshold = {3'd0, 3'd2};
    tick();
    check("thr_lo_id", 64'(irq_id_o[5:0]), 64'd4);

    // Claim ID 4 on target 0.
    claim_valid_i = 2'b01;
    tick();
    claim_valid_i = 2'b00;
    check("clm_id",       64'(claim_id_o[5:0]), 64'd4);
    check("clm_ack",      64'(claim_ack_o),     64'b01);
    check("clm_inflight", 64'(inflight_o),      64'h8);
    check("clm_irq_id",   64'(irq_id_o[5:0]),   64'd0);
    tick();
    check("clm_ack_pulse", 64'(claim_ack_o),     64'b00);
    check("clm_id_hold",   64'(claim_id_o[5:0]), 64'd4);

    // Complete ID 4: source reappears immediately while still pending.
    complete_valid_i = 2'b01;
    complete_id_i    = {6'd0, 6'd4};
    tick();
    complete_valid_i = 2'b00;
    check("cmp_inflight", 64'(inflight_o),    64'h0);
    check("cmp_irq_id",   64'(irq_id_o[5:0]), 64'd4);
    check_err("cmp_err", 2'b00);

    // Threshold MAX_PRIO masks everything.
    set_prio(3, 7);
    threshold = {3'd0, 3'd7};
    tick();
    check("thr_max_irq", 64'(irq_o), 64'b00);

    // Shared source 6 (ID 7) on both targets, simultaneous claim.
    ip = '0; ip[6] = 1'b1;
    prio = '0; set_prio(6, 4);
    ie = '0; ie[6] = 1'b1; ie[NS + 6] = 1'b1;
    threshold = '0;
    tick();
    check("shr_ids", 64'(irq_id_o), 64'({6'd7, 6'd7}));
    claim_valid_i = 2'b11;
    tick();
    claim_valid_i = 2'b00;
    check("shr_claim_ids", 64'(claim_id_o),  64'({6'd0, 6'd7}));
    check("shr_ack",       64'(claim_ack_o), 64'b11);
    check("shr_inflight",  64'(inflight_o),  64'h40);
    check("shr_irq_ids",   64'(irq_id_o),    64'h0);

    // Target 1 completing a source owned by target 0 is ignored.
    complete_valid_i = 2'b10;
    complete_id_i    = {6'd7, 6'd0};
    tick();
    complete_valid_i = 2'b00;
    check("own_inflight", 64'(inflight_o), 64'h40);
    check_err("own_err", 2'b10);
    tick();
    check_err("own_err_pulse", 2'b00);

    // Out-of-range IDs 0 and 33 are ignored.
    complete_valid_i = 2'b01;
    complete_id_i    = {6'd0, 6'd0};
    tick();
    check("bad0_inflight", 64'(inflight_o), 64'h40);
    check_err("bad0_err", 2'b01);
    complete_id_i = {6'd0, 6'd33};
    tick();
    complete_valid_i = 2'b00;
    check("bad33_inflight", 64'(inflight_o), 64'h40);
    check_err("bad33_err", 2'b01);

    // Owner completes: source offered to both targets again.
    complete_valid_i = 2'b01;
    complete_id_i    = {6'd0, 6'd7};
    tick();
    complete_valid_i = 2'b00;
    check("own_cmp_inflight", 64'(inflight_o), 64'h0);
    check("own_cmp_ids",      64'(irq_id_o),   64'({6'd7, 6'd7}));

    // Back-to-back claims from target 0: ID 4 then ID 7.
    ip[3] = 1'b1;
    set_prio(3, 5);
    ie = '0; ie[3] = 1'b1; ie[6] = 1'b1;
    tick();
    check("b2b_pre_id", 64'(irq_id_o[5:0]), 64'd4);
    claim_valid_i = 2'b01;
    tick();
    check("b2b_claim1", 64'(claim_id_o[5:0]), 64'd4);
    check("b2b_next",   64'(irq_id_o[5:0]),   64'd7);
    tick();
    claim_valid_i = 2'b00;
    check("b2b_claim2",   64'(claim_id_o[5:0]), 64'd7);
    check("b2b_inflight", 64'(inflight_o),      64'h48);
    check("b2b_irq",      64'(irq_o),           64'b00);

    // Mid-operation reset drops in-flight state.
    rst_i = 1'b1;
    tick();
    check("mrst_inflight", 64'(inflight_o), 64'h0);
    check("mrst_claim_id", 64'(claim_id_o), 64'h0);
    check("mrst_irq",      64'(irq_o),      64'h0);
    rst_i = 1'b0;
    tick();
    check("post_rst_id", 64'(irq_id_o[5:0]), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
